// File: rtl/hazard_ctrl_pipe_if.sv
// rtl/hazard_ctrl_pipe_if.sv - decode-side inputs and E/M/W hazard-facing outputs of hazard_ctrl_pipe
interface hazard_ctrl_pipe_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       RA1D;
  logic [3:0]       RA2D;
  logic [3:0]       WA3D;
  logic             RegWriteD;
  logic             MemtoRegD;
  logic             PCSrcD;
  logic             isBLD;
  logic             CondExE;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;

  logic [3:0]       RA1E;
  logic [3:0]       RA2E;
  logic [3:0]       WA3E;
  logic             MemtoRegE;
  logic             PCSrcE;
  logic             isBLE;
  logic [3:0]       WA3M;
  logic [3:0]       WA3W;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             PCSrcM;
  logic             PCSrcW;
  logic             w_mux_M;
  logic             w_mux_W;
  logic             bl_shadow;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, isBLD,
           CondExE, StallD, FlushD, FlushE,
    input  RA1E, RA2E, WA3E, MemtoRegE, PCSrcE, isBLE, WA3M, WA3W,
           RegWriteM, RegWriteW, PCSrcM, PCSrcW, w_mux_M, w_mux_W,
           bl_shadow, stall_cnt, flush_cnt
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, isBLD,
           CondExE, StallD, FlushD, FlushE,
    output RA1E, RA2E, WA3E, MemtoRegE, PCSrcE, isBLE, WA3M, WA3W,
           RegWriteM, RegWriteW, PCSrcM, PCSrcW, w_mux_M, w_mux_W,
           bl_shadow, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_pipe.sv
// rtl/hazard_ctrl_pipe.sv - D->E->M->W control pipeline feeding the hazard unit, with BL shadow and event counters
module hazard_ctrl_pipe #(
  parameter int CNT_W     = 16,
  parameter int BL_SHADOW = 2
) (
  input  logic                clk,
  input  logic                reset,
  hazard_ctrl_pipe_if.slave   bus
);
  logic [3:0]       ra1_e_q, ra1_e_d;
  logic [3:0]       ra2_e_q, ra2_e_d;
  logic [3:0]       wa3_e_q, wa3_e_d;
  logic             regwrite_e_q, regwrite_e_d;
  logic             memtoreg_e_q, memtoreg_e_d;
  logic             pcsrc_e_q, pcsrc_e_d;
  logic             isbl_e_q, isbl_e_d;

  logic [3:0]       wa3_m_q, wa3_w_q;
  logic             regwrite_m_q, regwrite_w_q;
  logic             pcsrc_m_q, pcsrc_w_q;
  logic             link_m_q, link_w_q;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             regwrite_eg;
  logic             pcsrc_eg;
  logic             link_e;

  // FlushE wins over decode content; StallD never holds E because the hazard unit pairs it with FlushE
  always_comb begin
    ra1_e_d      = bus.RA1D;
    ra2_e_d      = bus.RA2D;
    wa3_e_d      = bus.WA3D;
    regwrite_e_d = bus.RegWriteD;
    memtoreg_e_d = bus.MemtoRegD;
    pcsrc_e_d    = bus.PCSrcD;
    isbl_e_d     = bus.isBLD;
    if (bus.FlushE) begin
      ra1_e_d      = 4'd0;
      ra2_e_d      = 4'd0;
      wa3_e_d      = 4'd0;
      regwrite_e_d = 1'b0;
      memtoreg_e_d = 1'b0;
      pcsrc_e_d    = 1'b0;
      isbl_e_d     = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.StallD && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((bus.FlushD || bus.FlushE) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign regwrite_eg = regwrite_e_q & bus.CondExE;
  assign pcsrc_eg    = pcsrc_e_q & bus.CondExE;
  assign link_e      = isbl_e_q & bus.CondExE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra1_e_q      <= 4'd0;
      ra2_e_q      <= 4'd0;
      wa3_e_q      <= 4'd0;
      regwrite_e_q <= 1'b0;
      memtoreg_e_q <= 1'b0;
      pcsrc_e_q    <= 1'b0;
      isbl_e_q     <= 1'b0;
      wa3_m_q      <= 4'd0;
      regwrite_m_q <= 1'b0;
      pcsrc_m_q    <= 1'b0;
      link_m_q     <= 1'b0;
      wa3_w_q      <= 4'd0;
      regwrite_w_q <= 1'b0;
      pcsrc_w_q    <= 1'b0;
      link_w_q     <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ra1_e_q      <= ra1_e_d;
      ra2_e_q      <= ra2_e_d;
      wa3_e_q      <= wa3_e_d;
      regwrite_e_q <= regwrite_e_d;
      memtoreg_e_q <= memtoreg_e_d;
      pcsrc_e_q    <= pcsrc_e_d;
      isbl_e_q     <= isbl_e_d;
      wa3_m_q      <= wa3_e_q;
      regwrite_m_q <= regwrite_eg;
      pcsrc_m_q    <= pcsrc_eg;
      link_m_q     <= link_e;
      wa3_w_q      <= wa3_m_q;
      regwrite_w_q <= regwrite_m_q;
      pcsrc_w_q    <= pcsrc_m_q;
      link_w_q     <= link_m_q;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.RA1E      = ra1_e_q;
  assign bus.RA2E      = ra2_e_q;
  assign bus.WA3E      = wa3_e_q;
  assign bus.MemtoRegE = memtoreg_e_q;
  assign bus.PCSrcE    = pcsrc_eg;
  assign bus.isBLE     = isbl_e_q;
  assign bus.WA3M      = wa3_m_q;
  assign bus.WA3W      = wa3_w_q;
  assign bus.RegWriteM = regwrite_m_q;
  assign bus.RegWriteW = regwrite_w_q;
  assign bus.PCSrcM    = pcsrc_m_q;
  assign bus.PCSrcW    = pcsrc_w_q;
  assign bus.w_mux_M   = link_m_q;
  assign bus.w_mux_W   = link_w_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

  // Shadow is built from registered link bits only, so it can never glitch from decode
  generate
    if (BL_SHADOW == 1) begin : g_shadow1
      assign bus.bl_shadow = link_m_q;
    end else begin : g_shadow2
      assign bus.bl_shadow = link_m_q | link_w_q;
    end
  endgenerate
endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// tb/tb_hazard_ctrl_pipe.sv - scoreboard bench for hazard_ctrl_pipe (BL_SHADOW 2 and 1, CNT_W 4)
module tb_hazard_ctrl_pipe;
  localparam int CW = 4;

  logic clk;
  logic reset;

  hazard_ctrl_pipe_if #(.CNT_W(CW)) if0 ();
  hazard_ctrl_pipe_if #(.CNT_W(CW)) if1 ();

  hazard_ctrl_pipe #(.CNT_W(CW), .BL_SHADOW(2)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  hazard_ctrl_pipe #(.CNT_W(CW), .BL_SHADOW(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  assign if1.RA1D      = if0.RA1D;
  assign if1.RA2D      = if0.RA2D;
  assign if1.WA3D      = if0.WA3D;
  assign if1.RegWriteD = if0.RegWriteD;
  assign if1.MemtoRegD = if0.MemtoRegD;
  assign if1.PCSrcD    = if0.PCSrcD;
  assign if1.isBLD     = if0.isBLD;
  assign if1.CondExE   = if0.CondExE;
  assign if1.StallD    = if0.StallD;
  assign if1.FlushD    = if0.FlushD;
  assign if1.FlushE    = if0.FlushE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ra1e, ra2e, wa3e;
    logic       me, pce, ble;
    logic [3:0] wa3m, wa3w;
    logic       rwm, rww, pcm, pcw, wmm, wmw, sh2, sh1;
    logic [3:0] sc, fc;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  // reference pipeline state
  logic [3:0] e_ra1, e_ra2, e_wa3, m_wa3, w_wa3;
  logic       e_rw, e_me, e_pc, e_bl;
  logic       m_rw, m_pc, m_ln, w_rw, w_pc, w_ln;
  logic [3:0] sc, fc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
  endtask

  task automatic model_reset();
    {e_ra1, e_ra2, e_wa3, m_wa3, w_wa3} = '0;
    {e_rw, e_me, e_pc, e_bl, m_rw, m_pc, m_ln, w_rw, w_pc, w_ln} = '0;
    sc = '0;
    fc = '0;
  endtask

  task automatic compare_all(input exp_t e);
    chk("RA1E", if0.RA1E, e.ra1e);
    chk("RA2E", if0.RA2E, e.ra2e);
    chk("WA3E", if0.WA3E, e.wa3e);
    chk("MemtoRegE", if0.MemtoRegE, e.me);
    chk("PCSrcE", if0.PCSrcE, e.pce);
    chk("isBLE", if0.isBLE, e.ble);
    chk("WA3M", if0.WA3M, e.wa3m);
    chk("WA3W", if0.WA3W, e.wa3w);
    chk("RegWriteM", if0.RegWriteM, e.rwm);
    chk("RegWriteW", if0.RegWriteW, e.rww);
    chk("PCSrcM", if0.PCSrcM, e.pcm);
    chk("PCSrcW", if0.PCSrcW, e.pcw);
    chk("w_mux_M", if0.w_mux_M, e.wmm);
    chk("w_mux_W", if0.w_mux_W, e.wmw);
    chk("bl_shadow2", if0.bl_shadow, e.sh2);
    chk("bl_shadow1", if1.bl_shadow, e.sh1);
    chk("stall_cnt", if0.stall_cnt, e.sc);
    chk("flush_cnt", if0.flush_cnt, e.fc);
  endtask

  task automatic step(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                      input logic rw, input logic me, input logic pc, input logic bl,
                      input logic cond, input logic stall, input logic fld, input logic fle);
    exp_t e;
    if0.RA1D = ra1; if0.RA2D = ra2; if0.WA3D = wa3;
    if0.RegWriteD = rw; if0.MemtoRegD = me; if0.PCSrcD = pc; if0.isBLD = bl;
    if0.CondExE = cond; if0.StallD = stall; if0.FlushD = fld; if0.FlushE = fle;
    w_wa3 = m_wa3; w_rw = m_rw; w_pc = m_pc; w_ln = m_ln;
    m_wa3 = e_wa3; m_rw = e_rw & cond; m_pc = e_pc & cond; m_ln = e_bl & cond;
    if (fle) begin
      {e_ra1, e_ra2, e_wa3} = '0;
      {e_rw, e_me, e_pc, e_bl} = '0;
    end else begin
      e_ra1 = ra1; e_ra2 = ra2; e_wa3 = wa3;
      e_rw = rw; e_me = me; e_pc = pc; e_bl = bl;
    end
    if (stall && sc != 4'hf) sc = sc + 4'd1;
    if ((fld || fle) && fc != 4'hf) fc = fc + 4'd1;
    e = '{ra1e: e_ra1, ra2e: e_ra2, wa3e: e_wa3, me: e_me, pce: e_pc & cond, ble: e_bl,
          wa3m: m_wa3, wa3w: w_wa3, rwm: m_rw, rww: w_rw, pcm: m_pc, pcw: w_pc,
          wmm: m_ln, wmw: w_ln, sh2: m_ln | w_ln, sh1: m_ln, sc: sc, fc: fc};
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_all(sb.pop_front());
  endtask

  task automatic nop(input logic cond);
    step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, cond, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_WA3E"}, if0.WA3E, 0);
    chk({tag, "_RA1E"}, if0.RA1E, 0);
    chk({tag, "_WA3M"}, if0.WA3M, 0);
    chk({tag, "_WA3W"}, if0.WA3W, 0);
    chk({tag, "_RegWriteM"}, if0.RegWriteM, 0);
    chk({tag, "_RegWriteW"}, if0.RegWriteW, 0);
    chk({tag, "_w_mux_M"}, if0.w_mux_M, 0);
    chk({tag, "_bl_shadow"}, if0.bl_shadow, 0);
    chk({tag, "_stall_cnt"}, if0.stall_cnt, 0);
    chk({tag, "_flush_cnt"}, if0.flush_cnt, 0);
  endtask

  initial begin
    reset = 1'b1;
    if0.RA1D = '0; if0.RA2D = '0; if0.WA3D = '0;
    if0.RegWriteD = 1'b0; if0.MemtoRegD = 1'b0; if0.PCSrcD = 1'b0; if0.isBLD = 1'b0;
    if0.CondExE = 1'b1; if0.StallD = 1'b0; if0.FlushD = 1'b0; if0.FlushE = 1'b0;
    model_reset();
    #12;
    check_all_zero("rst");
    reset = 1'b0;

    // straight flow
    step(4'd3, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) nop(1'b1);

    // load-use bubble: load, then stall+flushE for one cycle
    step(4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd2, 4'd6, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) nop(1'b1);

    // condition fail on a PC-writing instruction
    step(4'd1, 4'd2, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    nop(1'b0);
    repeat (3) nop(1'b1);

    // taken BL
    step(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) nop(1'b1);

    // untaken BL never opens the shadow
    step(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    nop(1'b0);
    repeat (3) nop(1'b1);

    // FlushD alone, then both flushes together
    step(4'd8, 4'd9, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(4'd8, 4'd9, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    // counter saturation
    repeat (20) step(4'd1, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      step(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
           1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(1)), 1'($urandom_range(3) != 0), 1'($urandom_range(3) == 0),
           1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0));
    end

    // async reset mid-cycle with WA3M=7 and RegWriteW=1
    step(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    nop(1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    reset = 1'b0;
    step(4'd9, 4'd10, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) nop(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_pipe.md
Name: hazard_ctrl_pipe

Overview:
- Pipeline-register bank that carries hazard-relevant control fields from Decode through Execute, Memory and Writeback.
- Consumes the hazard unit's stall/flush commands and produces the E/M/W-stage register numbers and control bits the hazard unit compares against.
- Sits between the decoder/condition unit and the hazard unit, closing the stall/flush/forward loop.
- Also tracks the branch-with-link (BL) shadow window and keeps saturating stall/flush event counters for debug.

Parameters:
- CNT_W, 16, width of each saturating event counter.
- BL_SHADOW, 2, number of stages after Execute (M, W) for which the BL shadow flag stays asserted; legal values 1 or 2.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- RA1D  input  4  decode source register 1.
- RA2D  input  4  decode source register 2.
- WA3D  input  4  decode destination register.
- RegWriteD  input  1  decode register-write enable.
- MemtoRegD  input  1  decode load flag.
- PCSrcD  input  1  decode writes PC (unconditioned).
- isBLD  input  1  decode instruction is BL; link write to R14.
- CondExE  input  1  condition passed for the instruction in Execute.
- StallD  input  1  from hazard unit.
- FlushD  input  1  from hazard unit.
- FlushE  input  1  from hazard unit.
- RA1E  output  4  execute source register 1.
- RA2E  output  4  execute source register 2.
- WA3E  output  4  execute destination register.
- MemtoRegE  output  1  execute load flag.
- PCSrcE  output  1  execute PC write, gated by CondExE.
- isBLE  output  1  execute BL flag, ungated.
- WA3M  output  4  memory-stage destination register.
- WA3W  output  4  writeback-stage destination register.
- RegWriteM  output  1  memory-stage register-write enable.
- RegWriteW  output  1  writeback-stage register-write enable.
- PCSrcM  output  1  memory-stage PC write.
- PCSrcW  output  1  writeback-stage PC write.
- w_mux_M  output  1  memory-stage link write to R14.
- w_mux_W  output  1  writeback-stage link write to R14.
- bl_shadow  output  1  a taken BL is in M (or M/W per BL_SHADOW).
- stall_cnt  output  CNT_W  saturating count of StallD cycles.
- flush_cnt  output  CNT_W  saturating count of FlushD or FlushE cycles.

Behaviour:
- Reset (asynchronous, takes effect immediately): every E/M/W register and both counters clear to 0. All outputs read 0.
- D to E register, every rising edge:
  - FlushE=1: E fields load 0 (bubble: RegWrite=0, MemtoReg=0, PCSrc=0, isBL=0, register numbers 0).
  - Otherwise E loads the D fields.
  - StallD does not hold E; the hazard unit pairs StallD with FlushE.
  - FlushE takes priority over any D content.
- FlushD has no effect on these registers; the F/D register owns it. It only feeds flush_cnt.
- Condition gating in E:
  - RegWriteEg = RegWriteE_raw & CondExE.
  - PCSrcE = PCSrcE_raw & CondExE.
  - linkE = isBLE & CondExE.
  - MemtoRegE and the register numbers are ungated.
- E to M register, unconditional each edge: WA3M, RegWriteM = RegWriteEg, PCSrcM = PCSrcE, w_mux_M = linkE.
- M to W register, unconditional each edge: WA3W, RegWriteW, PCSrcW, w_mux_W.
- Latency: a D field appears at E one cycle later, at M two cycles later, at W three cycles later.
- BL shadow:
  - BL_SHADOW=2: bl_shadow = w_mux_M | w_mux_W.
  - BL_SHADOW=1: bl_shadow = w_mux_M.
  - It is registered-path only; it is never combinational from D.
- Counters:
  - stall_cnt increments on each edge where StallD=1.
  - flush_cnt increments on each edge where FlushD|FlushE=1. Simultaneous FlushD and FlushE counts once.
  - Both saturate at all-ones and never wrap.
- Simultaneous StallD and FlushE: E becomes a bubble and stall_cnt increments. Both registers update on the same edge.
- Reset asserted mid-stream: all in-flight control is discarded. The first instruction accepted after reset release reaches E on the first edge.

Test Plan:
- Straight flow: RA1D=3, RA2D=4, WA3D=5, RegWriteD=1, CondExE=1, no flush -> next cycle RA1E=3/RA2E=4/WA3E=5; WA3M=5 and RegWriteM=1 after 2 cycles; WA3W=5 and RegWriteW=1 after 3 cycles.
- Load-use bubble: MemtoRegD=1, WA3D=2 followed by StallD=1 and FlushE=1 for one cycle -> E shows MemtoRegE=1 then all-zero bubble; stall_cnt=1, flush_cnt=1; WA3M follows 2 then 0.
- Condition fail: RegWriteD=1, PCSrcD=1, WA3D=15, CondExE=0 in E -> PCSrcE=0, RegWriteM=0, PCSrcM=0, PCSrcW=0.
- BL: isBLD=1, WA3D=15, PCSrcD=1, CondExE=1, BL_SHADOW=2 -> w_mux_M=1 at cycle+2, w_mux_W=1 at cycle+3, bl_shadow high for exactly those 2 cycles; with BL_SHADOW=1, high for 1 cycle.
- Saturation: CNT_W=4 with StallD held 20 cycles -> stall_cnt reaches 15 and stays at 15.
- Async reset: assert reset mid-cycle with WA3M=7 and RegWriteW=1 -> all outputs 0 before the next clock edge; counters 0.
